// File: rtl/mips_pkg.sv
// Shared types and widths for the register-file writeback path.
package mips_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2**REG_ADDR_W;

   // One pending register-file write: destination index and result.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] dst;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO of pending mul/div writebacks.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module wb_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t wr_req,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           push_ok;
   logic           pop_ok;
   wb_req_t        mem [DEPTH];

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Entry storage needs no reset: it is only read when the pointers say it is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= wr_req;
   end

endmodule

// File: rtl/reg_writeback_arb.sv
// Register-file write port arbiter: ALU first, then queued mul/div results, plus pending-write scoreboard.
// Optional macro WB_BYPASS_EN exposes the write stage as a bypass source instead of stalling on it.
module reg_writeback_arb #(
   parameter int DATA_W     = mips_pkg::DATA_W,
   parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
   parameter int MD_DEPTH   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_reg,
   input  logic [DATA_W-1:0]     alu_data,
   input  logic                  md_valid,
   output logic                  md_ready,
   input  logic [REG_ADDR_W-1:0] md_reg,
   input  logic [DATA_W-1:0]     md_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_reg,
   input  logic [REG_ADDR_W-1:0] rd_reg1,
   input  logic [REG_ADDR_W-1:0] rd_reg2,
   output logic                  rd_busy1,
   output logic                  rd_busy2,
`ifdef WB_BYPASS_EN
   output logic                  byp_hit1,
   output logic                  byp_hit2,
   output logic [DATA_W-1:0]     byp_data,
`endif
   output logic                  reg_write_en,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0]     write_data
);

   import mips_pkg::wb_req_t;

   localparam int NUM_REGS = 2**REG_ADDR_W;

   wb_req_t             md_req;
   wb_req_t             alu_req;
   wb_req_t             head;
   wb_req_t             sel_req;
   logic                q_full;
   logic                q_empty;
   logic                push;
   logic                pop;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic                wb_hit1;
   logic                wb_hit2;

   assign md_req  = '{dst: md_reg, data: md_data};
   assign alu_req = '{dst: alu_reg, data: alu_data};

   assign md_ready = !q_full;
   assign push     = md_valid && !q_full;
   assign pop      = !q_empty && !alu_valid;
   assign sel_req  = alu_valid ? alu_req : head;

   wb_fifo #(
      .DEPTH (MD_DEPTH)
   ) u_md_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .pop    (pop),
      .wr_req (md_req),
      .head   (head),
      .full   (q_full),
      .empty  (q_empty)
   );

   // Destination 0 still consumes the request but never writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_en <= 1'b0;
         write_reg    <= '0;
         write_data   <= '0;
      end else if (alu_valid || pop) begin
         reg_write_en <= (sel_req.dst != '0);
         write_reg    <= sel_req.dst;
         write_data   <= sel_req.data;
      end else begin
         reg_write_en <= 1'b0;
      end
   end

   // A new issue to a register overrides the retirement of its previous result.
   always_comb begin
      busy_nxt = busy;
      if (pop)         busy_nxt[head.dst]  = 1'b0;
      if (issue_valid) busy_nxt[issue_reg] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   assign wb_hit1 = reg_write_en && (write_reg == rd_reg1) && (rd_reg1 != '0);
   assign wb_hit2 = reg_write_en && (write_reg == rd_reg2) && (rd_reg2 != '0);

`ifdef WB_BYPASS_EN
   assign byp_hit1 = wb_hit1;
   assign byp_hit2 = wb_hit2;
   assign byp_data = write_data;
   assign rd_busy1 = busy[rd_reg1];
   assign rd_busy2 = busy[rd_reg2];
`else
   assign rd_busy1 = busy[rd_reg1] | wb_hit1;
   assign rd_busy2 = busy[rd_reg2] | wb_hit2;
`endif

endmodule

// File: tb/tb_reg_writeback_arb.sv
// Self-checking bench for reg_writeback_arb; expected writes are queued and matched against the write port.
module tb_reg_writeback_arb;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_reg = '0;
   logic [31:0] alu_data = '0;
   logic        md_valid = 1'b0;
   logic        md_ready;
   logic [4:0]  md_reg = '0;
   logic [31:0] md_data = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_reg = '0;
   logic [4:0]  rd_reg1 = '0;
   logic [4:0]  rd_reg2 = '0;
   logic        rd_busy1;
   logic        rd_busy2;
`ifdef WB_BYPASS_EN
   logic        byp_hit1;
   logic        byp_hit2;
   logic [31:0] byp_data;
`endif
   logic        reg_write_en;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   reg_writeback_arb dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_reg      (alu_reg),
      .alu_data     (alu_data),
      .md_valid     (md_valid),
      .md_ready     (md_ready),
      .md_reg       (md_reg),
      .md_data      (md_data),
      .issue_valid  (issue_valid),
      .issue_reg    (issue_reg),
      .rd_reg1      (rd_reg1),
      .rd_reg2      (rd_reg2),
      .rd_busy1     (rd_busy1),
      .rd_busy2     (rd_busy2),
`ifdef WB_BYPASS_EN
      .byp_hit1     (byp_hit1),
      .byp_hit2     (byp_hit2),
      .byp_data     (byp_data),
`endif
      .reg_write_en (reg_write_en),
      .write_reg    (write_reg),
      .write_data   (write_data)
   );

   // Write-port monitor: every write must be the next expected one.
   always @(negedge clk) begin
      if (mon_en && !rst && reg_write_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got write reg %0d data %h, required no write", write_reg, write_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (write_reg !== mon_e.r || write_data !== mon_e.d) begin
               errors++;
               $display("FAIL wb_order: got reg %0d data %h, required reg %0d data %h",
                        write_reg, write_data, mon_e.r, mon_e.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [4:0] r, input logic [31:0] d);
      exp_t e;
      e.r = r;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic drain(output int left);
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         tick();
         n++;
      end
      left = exp_q.size();
      exp_q.delete();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if (reg_write_en !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_wb: got en %b reg %0d data %h, required 0 0 0", reg_write_en, write_reg, write_data);
      end
      checks++;
      if (md_ready !== 1'b1 || rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: got md_ready %b busy %b%b, required 1 00", md_ready, rd_busy1, rd_busy2);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
      #3;
      checks++;
      if (md_ready !== 1'b1 || reg_write_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got md_ready %b en %b, required 1 0", md_ready, reg_write_en);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_alu();
      int left;
      tick();
      alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
      push_exp(5'd5, 32'hDEADBEEF);
      tick();
      alu_valid = 1'b0;
      #4;
      checks++;
      if (reg_write_en !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL alu_latency: got en %b reg %0d data %h, required 1 5 deadbeef", reg_write_en, write_reg, write_data);
      end
      tick();
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h0BADF00D;
      tick();
      alu_valid = 1'b0;
      #4;
      checks++;
      if (reg_write_en !== 1'b0) begin
         errors++;
         $display("FAIL alu_reg0: got en %b, required 0", reg_write_en);
      end
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL alu_drain: got %0d writes outstanding, required 0", left);
      end
   endtask

   task automatic test_pending();
      int left;
      tick();
      issue_valid = 1'b1; issue_reg = 5'd9; rd_reg1 = 5'd9;
      tick();
      issue_valid = 1'b0;
      md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h12345678;
      push_exp(5'd9, 32'h12345678);
      #4;
      checks++;
      if (rd_busy1 !== 1'b1) begin
         errors++;
         $display("FAIL pend_issued: got rd_busy1 %b, required 1", rd_busy1);
      end
      tick();
      md_valid = 1'b0;
      #4;
      checks++;
      if (rd_busy1 !== 1'b1) begin
         errors++;
         $display("FAIL pend_queued: got rd_busy1 %b, required 1", rd_busy1);
      end
      tick();
      #4;
      checks++;
      if (rd_busy1 !== !BYP) begin
         errors++;
         $display("FAIL pend_wstage: got rd_busy1 %b, required %b", rd_busy1, !BYP);
      end
`ifdef WB_BYPASS_EN
      checks++;
      if (byp_hit1 !== 1'b1 || byp_data !== 32'h12345678) begin
         errors++;
         $display("FAIL pend_bypass: got hit %b data %h, required 1 12345678", byp_hit1, byp_data);
      end
`endif
      tick();
      #4;
      checks++;
      if (rd_busy1 !== 1'b0) begin
         errors++;
         $display("FAIL pend_cleared: got rd_busy1 %b, required 0", rd_busy1);
      end
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL pend_drain: got %0d writes outstanding, required 0", left);
      end
      rd_reg1 = 5'd0;
   endtask

   task automatic test_back_to_back();
      int   left;
      logic exp_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 1; i <= 4; i++) push_exp(5'(i), 32'hA000_0000 + 32'(i));
      push_exp(5'd20, 32'hB000_0020);
      push_exp(5'd21, 32'hB000_0021);
      tick();
      for (int i = 0; i < 5; i++) begin
         alu_valid = (i < 4);
         alu_reg   = 5'(i + 1);
         alu_data  = 32'hA000_0000 + 32'(i + 1);
         md_valid  = (i < 4);
         md_reg    = (i < 2) ? 5'(20 + i) : 5'd22;
         md_data   = (i < 2) ? 32'hB000_0020 + 32'(i) : 32'hB000_0022;
         #4;
         checks++;
         if (md_ready !== exp_rdy[i]) begin
            errors++;
            $display("FAIL b2b_ready_%0d: got md_ready %b, required %b", i, md_ready, exp_rdy[i]);
         end
         tick();
      end
      md_valid = 1'b0;
      #4;
      checks++;
      if (md_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready_after_pop: got md_ready %b, required 1", md_ready);
      end
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d writes outstanding, required 0", left);
      end
   endtask

   task automatic test_set_wins();
      int left;
      tick();
      issue_valid = 1'b1; issue_reg = 5'd7; rd_reg1 = 5'd7;
      tick();
      issue_valid = 1'b0;
      md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h0000_0077;
      push_exp(5'd7, 32'h0000_0077);
      tick();
      md_valid = 1'b0;
      issue_valid = 1'b1; issue_reg = 5'd7;
      tick();
      issue_valid = 1'b0;
      tick();
      #4;
      checks++;
      if (rd_busy1 !== 1'b1) begin
         errors++;
         $display("FAIL set_wins: got rd_busy1 %b, required 1", rd_busy1);
      end
      tick();
      md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h0000_0078;
      push_exp(5'd7, 32'h0000_0078);
      tick();
      md_valid = 1'b0;
      tick();
      tick();
      #4;
      checks++;
      if (rd_busy1 !== 1'b0) begin
         errors++;
         $display("FAIL set_wins_clear: got rd_busy1 %b, required 0", rd_busy1);
      end
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL set_wins_drain: got %0d writes outstanding, required 0", left);
      end
      rd_reg1 = 5'd0;
   endtask

   task automatic test_reg0();
      int left;
      tick();
      issue_valid = 1'b1; issue_reg = 5'd0; rd_reg1 = 5'd0; rd_reg2 = 5'd3;
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h1111_1111;
      md_valid = 1'b1; md_reg = 5'd0; md_data = 32'h2222_2222;
      tick();
      issue_valid = 1'b0; md_valid = 1'b0;
      alu_reg = 5'd3; alu_data = 32'h0000_0033;
      push_exp(5'd3, 32'h0000_0033);
      #4;
      checks++;
      if (rd_busy1 !== 1'b0 || reg_write_en !== 1'b0 || rd_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL reg0_issue: got busy1 %b en %b busy2 %b, required 0 0 0", rd_busy1, reg_write_en, rd_busy2);
      end
      tick();
      alu_valid = 1'b0;
      #4;
      checks++;
      if (rd_busy2 !== !BYP || rd_busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reg0_alu_hazard: got busy2 %b busy1 %b, required %b 0", rd_busy2, rd_busy1, !BYP);
      end
`ifdef WB_BYPASS_EN
      checks++;
      if (byp_hit2 !== 1'b1 || byp_data !== 32'h0000_0033 || byp_hit1 !== 1'b0) begin
         errors++;
         $display("FAIL reg0_bypass: got hit2 %b data %h hit1 %b, required 1 00000033 0", byp_hit2, byp_data, byp_hit1);
      end
`endif
      tick();
      #4;
      checks++;
      if (reg_write_en !== 1'b0 || md_ready !== 1'b1 || rd_busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reg0_md_pop: got en %b md_ready %b busy1 %b, required 0 1 0", reg_write_en, md_ready, rd_busy1);
      end
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL reg0_drain: got %0d writes outstanding, required 0", left);
      end
      rd_reg2 = 5'd0;
   endtask

   task automatic test_reset_mid();
      mon_en = 1'b0;
      tick();
      issue_valid = 1'b1; issue_reg = 5'd12; rd_reg1 = 5'd12; rd_reg2 = 5'd13;
      tick();
      issue_reg = 5'd13;
      alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h0000_0003;
      md_valid = 1'b1; md_reg = 5'd12; md_data = 32'hC000_0012;
      tick();
      issue_valid = 1'b0;
      md_reg = 5'd13; md_data = 32'hC000_0013;
      tick();
      md_valid = 1'b0; alu_valid = 1'b0;
      #1;
      checks++;
      if (md_ready !== 1'b0 || rd_busy1 !== 1'b1 || reg_write_en !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: got md_ready %b busy1 %b en %b, required 0 1 1", md_ready, rd_busy1, reg_write_en);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (reg_write_en !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_wb: got en %b reg %0d data %h, required 0 0 0", reg_write_en, write_reg, write_data);
      end
      checks++;
      if (md_ready !== 1'b1 || rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_status: got md_ready %b busy %b%b, required 1 00", md_ready, rd_busy1, rd_busy2);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         #3;
         checks++;
         if (reg_write_en !== 1'b0 || rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flushed_%0d: got en %b busy %b%b, required 0 00", i, reg_write_en, rd_busy1, rd_busy2);
         end
      end
      exp_q.delete();
      mon_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_pending();
      test_back_to_back();
      test_set_wins();
      test_reg0();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
